// File: rtl/button_gesture_ctrl.sv
// rtl/button_gesture_ctrl.sv - short/long/double press classifier behind the debouncer
//
// Purpose: classifies each press sequence that starts from idle into exactly one
// event (short, long or double) and emits it as a registered one-cycle pulse.
// A single saturating counter times both the hold (e_press1) and the
// release-to-next-press gap (e_gap).
//
// Ports:
//   i_clk     system clock
//   i_rst     asynchronous active-high reset
//   i_level   debounced switch level
//   i_rising  debounced rising pulse (one cycle; i_level may still be low)
//   o_short   one-cycle pulse: single press completed, gap expired
//   o_long    one-cycle pulse: hold reached LONG_CYCLES
//   o_double  one-cycle pulse: second press released inside the gap window
//   o_busy    high whenever the sequencer is not idle
module button_gesture_ctrl #(
  parameter int LONG_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 30_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  input  logic i_rising,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_busy
);

  localparam int CNT_MAX = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  typedef enum logic [2:0] {
    e_idle   = 3'd0,
    e_press1 = 3'd1,
    e_hold   = 3'd2,
    e_gap    = 3'd3,
    e_press2 = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_short;
  logic          r_long;
  logic          r_double;
  logic          w_short;
  logic          w_long;
  logic          w_double;
  logic          w_counting;

  // State register plus the registered event pulses and the shared counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= e_idle;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      // Counter restarts on any state change so each timed state sees 0 on entry.
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (w_counting && (r_cnt != CNT_SAT)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Next-state logic. Release beats long detection in e_press1; a new press
  // beats the gap timeout in e_gap.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      e_idle: begin
        if (i_rising) w_state_next = e_press1;
      end
      e_press1: begin
        if (!i_level)                w_state_next = e_gap;
        else if (r_cnt == LONG_LAST) w_state_next = e_hold;
      end
      e_hold: begin
        if (!i_level) w_state_next = e_idle;
      end
      e_gap: begin
        if (i_rising)               w_state_next = e_press2;
        else if (r_cnt == GAP_LAST) w_state_next = e_idle;
      end
      e_press2: begin
        if (!i_level) w_state_next = e_idle;
      end
      default: w_state_next = e_idle;
    endcase
  end

  // Output logic: pulse conditions mirror the transitions above and are
  // registered so each event lands in the cycle after its condition.
  always_comb begin
    w_counting = (r_state == e_press1) || (r_state == e_gap);
    w_long     = (r_state == e_press1) && i_level && (r_cnt == LONG_LAST);
    w_short    = (r_state == e_gap) && !i_rising && (r_cnt == GAP_LAST);
    w_double   = (r_state == e_press2) && !i_level;
  end

  assign o_short  = r_short;
  assign o_long   = r_long;
  assign o_double = r_double;
  assign o_busy   = (r_state != e_idle);

endmodule

// File: tb/tb_button_gesture_ctrl.sv
// tb/tb_button_gesture_ctrl.sv - scoreboard bench for button_gesture_ctrl
module tb_button_gesture_ctrl;

  localparam int LONG = 20;
  localparam int GAP  = 10;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_level;
  logic i_rising;
  logic o_short;
  logic o_long;
  logic o_double;
  logic o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Expected events: kind 0 = short, 1 = long, 2 = double; absolute cycle.
  int exp_kind[$];
  int exp_cyc[$];

  button_gesture_ctrl #(
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_level (i_level),
    .i_rising(i_rising),
    .o_short (o_short),
    .o_long  (o_long),
    .o_double(o_double),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    exp_kind.push_back(kind);
    exp_cyc.push_back(at);
  endtask

  // Drive one cycle of inputs; afterwards o_busy must be high while the
  // sequence that started at t0 is still inside its [1, endc) window.
  task automatic dr(input logic lvl, input logic rise, input int t0, input int endc);
    i_level  = lvl;
    i_rising = rise;
    @(posedge i_clk);
    #1;
    i_rising = 1'b0;
    chk("busy", int'(o_busy), ((cyc - t0) < endc) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) dr(1'($urandom_range(0, 1)), 1'b0, cyc, 0);
  endtask

  // One gesture: press in cycle 0, level high for h1 cycles, release sampled
  // at r = h1+1. If 1 <= g <= GAP a second press arrives at r+g, held h2
  // cycles. Expected outcome is worked out from the timing rules up front.
  task automatic run_seq(input int h1, input int g, input int h2, input bit spur, input bit lvl0);
    int t0;
    int r;
    int s;
    int endc;
    bit dbl;
    t0  = cyc;
    r   = h1 + 1;
    dbl = (r <= LONG) && (g >= 1) && (g <= GAP);
    if (r > LONG) begin
      push(1, t0 + LONG + 1);
      endc = r + 1;
    end else if (dbl) begin
      s = r + g + h2 + 1;
      push(2, t0 + s + 1);
      endc = s + 1;
    end else begin
      push(0, t0 + r + GAP + 1);
      endc = r + GAP + 1;
    end
    dr(lvl0, 1'b1, t0, endc);
    for (int i = 1; i <= h1; i++) dr(1'b1, 1'(spur && ($urandom_range(0, 3) == 0)), t0, endc);
    dr(1'b0, 1'b0, t0, endc);
    if (r <= LONG) begin
      if (dbl) begin
        for (int c = r + 1; c < r + g; c++) dr(1'b0, 1'b0, t0, endc);
        dr(1'($urandom_range(0, 1)), 1'b1, t0, endc);
        for (int i = 1; i <= h2; i++) dr(1'b1, 1'(spur && ($urandom_range(0, 3) == 0)), t0, endc);
        dr(1'b0, 1'b0, t0, endc);
      end else begin
        for (int c = r + 1; c <= r + GAP; c++) dr(1'b0, 1'b0, t0, endc);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event pulse,
  // and flags any expected event whose cycle passes without a pulse.
  int m_np;
  int m_kind;
  int m_ek;
  int m_ec;
  always @(negedge i_clk) begin
    if (!i_rst) begin
      m_np = int'(o_short) + int'(o_long) + int'(o_double);
      if (m_np > 1) chk("onehot_pulses", m_np, 1);
      if (m_np != 0) begin
        m_kind = o_long ? 1 : (o_double ? 2 : 0);
        if (exp_cyc.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", m_kind, cyc);
        end else begin
          m_ek = exp_kind.pop_front();
          m_ec = exp_cyc.pop_front();
          chk("event_kind", m_kind, m_ek);
          chk("event_cycle", cyc, m_ec);
        end
      end else if (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
        m_ek = exp_kind.pop_front();
        m_ec = exp_cyc.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_pulse: kind %0d expected at cycle %0d, still absent at cycle %0d", m_ek, m_ec, cyc);
      end
    end
  end

  initial begin
    int t0;
    int g;
    i_rst    = 1'b1;
    i_level  = 1'b1;
    i_rising = 1'b0;

    // Reset held 3 cycles with level high, then the first cycle after release.
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      chk("rst_short", int'(o_short), 0);
      chk("rst_long", int'(o_long), 0);
      chk("rst_double", int'(o_double), 0);
      chk("rst_busy", int'(o_busy), 0);
    end
    i_rst   = 1'b0;
    i_level = 1'b0;
    @(posedge i_clk);
    #1;
    chk("post_rst_pulses", int'(o_short) + int'(o_long) + int'(o_double), 0);
    chk("post_rst_busy", int'(o_busy), 0);
    idle(2);

    // Directed: short, long, long/short boundary, double at gap timeout cycle.
    run_seq(5, 0, 0, 1'b0, 1'b0);
    idle(2);
    run_seq(40, 0, 0, 1'b0, 1'b0);
    idle(2);
    run_seq(LONG - 1, 0, 0, 1'b0, 1'b0);
    idle(2);
    run_seq(5, GAP, 2, 1'b0, 1'b0);
    idle(2);
    // Second press one cycle late: short fires, that press opens a new sequence.
    run_seq(5, GAP + 1, 0, 1'b0, 1'b0);
    run_seq(2, 3, 1, 1'b0, 1'b1);
    idle(2);

    // Reset in cycle 10 of a short press: the pending short is discarded.
    t0 = cyc;
    dr(1'b0, 1'b1, t0, 17);
    for (int i = 1; i <= 5; i++) dr(1'b1, 1'b0, t0, 17);
    for (int i = 6; i <= 9; i++) dr(1'b0, 1'b0, t0, 17);
    i_rst = 1'b1;
    exp_kind.delete();
    exp_cyc.delete();
    #1;
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_pulses", int'(o_short) + int'(o_long) + int'(o_double), 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    idle(12);
    run_seq(5, 0, 0, 1'b0, 1'b0);

    // Random gestures, back-to-back or with a few idle cycles between.
    for (int n = 0; n < 150; n++) begin
      g = $urandom_range(0, GAP + 2);
      run_seq($urandom_range(0, LONG + 5), g, $urandom_range(0, 8), 1'b1, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3));
    end

    idle(4);
    chk("scoreboard_empty", exp_cyc.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_gesture_ctrl.md
# button_gesture_ctrl

Gesture sequencer that sits directly downstream of the switch debouncer, consuming its debounced level and one-cycle rising pulse. It classifies each press sequence as a short press, a long press or a double press, and emits one registered single-cycle event pulse per sequence. A single shared cycle counter times both the hold and the inter-press gap. Application logic uses its outputs in place of raw button edges.

## Interface
- `LONG_CYCLES`, default 100_000_000: hold duration (clock cycles) that qualifies a long press; must be ≥ 2.
- `GAP_CYCLES`, default 30_000_000: maximum release-to-next-press gap (cycles) for a double press; must be ≥ 2.
- `i_clk` in 1: system clock; single clock domain.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_level` in 1: debounced switch level from the debouncer.
- `i_rising` in 1: debouncer rising pulse; high one cycle, and may coincide with `i_level` still low.
- `o_short` out 1: one-cycle pulse, short single press completed.
- `o_long` out 1: one-cycle pulse, hold reached `LONG_CYCLES`.
- `o_double` out 1: one-cycle pulse, second press released inside gap window.
- `o_busy` out 1: high whenever state ≠ e_idle.

## Operation
- One counter, width $clog2(max(LONG_CYCLES, GAP_CYCLES)+1). It clears on every state change and increments by 1 per cycle in e_press1 and e_gap. It saturates and never wraps.
- The state machine has five states: e_idle, e_press1, e_hold, e_gap, e_press2.
- **e_idle:**
  - `i_rising` → e_press1, with the counter at 0.
  - `i_level` alone, with no rising pulse, is ignored.
- **e_press1:**
  - `!i_level` → e_gap.
  - Otherwise, counter == LONG_CYCLES-1 → e_hold and assert `o_long`.
  - Release has priority over long detection in the same cycle.
- **e_hold:** `!i_level` → e_idle. No event is emitted on release.
- **e_gap:**
  - `i_rising` → e_press2.
  - Otherwise, counter == GAP_CYCLES-1 → e_idle and assert `o_short`.
  - `i_rising` has priority over timeout in the same cycle.
- **e_press2:** `!i_level` → e_idle and assert `o_double`. There is no long detection in this state.
- `i_rising` is ignored in e_press1, e_hold and e_press2.
- At most one of `o_short`, `o_long` and `o_double` is high in any cycle. Exactly one is emitted per sequence that starts from e_idle.
- Unreachable state encodings → e_idle, with no pulse.

## Timing
- **Reset:** state = e_idle, counter = 0. `o_short`, `o_long`, `o_double` and `o_busy` are all 0 while `i_rst` is high and in the first cycle after it deasserts.
- **Reset mid-sequence:** any pending event is discarded. No pulse is emitted after reset.
- **Event pulses:** registered. Each pulse is high in the cycle immediately after the cycle in which its transition condition was sampled, for exactly 1 cycle.
- **`o_busy`:** decoded from the state register. It rises in the cycle after `i_rising` is sampled and falls in the cycle after the terminating condition is sampled, coincident with any event pulse.
- **Long press:** with `i_rising` in cycle 0 and `i_level` held high, `o_long` is high in cycle LONG_CYCLES+1.
- **Short press:** with release first sampled low in cycle r, e_gap holds cycles r+1…r+GAP_CYCLES. `o_short` is high in cycle r+GAP_CYCLES+1.
- **Double press:** with the second release sampled in cycle s, `o_double` is high in cycle s+1.
- **Throughput:** a new `i_rising` is accepted in the first cycle after returning to e_idle.

## Test plan
Benches use LONG_CYCLES=20 and GAP_CYCLES=10.
- **Reset:** hold `i_rst` for 3 cycles with `i_level`=1 → all outputs 0 and `o_busy`=0.
- **Short press:** `i_rising` in cycle 0, `i_level` high in cycles 1–5, low from cycle 6 → `o_short` only in cycle 17; `o_busy` high in cycles 1–16 and falls in cycle 17.
- **Long press:** `i_rising` in cycle 0, `i_level` high in cycles 1–40 → `o_long` only in cycle 21, nothing on release, `o_busy` 0 from cycle 42.
- **Long/short boundary:** release sampled low exactly in cycle 20 (counter = 19) → no `o_long`; `o_short` in cycle 31.
- **Double press and gap boundary:**
  - First press released in cycle 6, then `i_rising` in cycle 16 (counter = 9, the timeout cycle), then second release sampled in cycle 19 → `o_double` in cycle 20 and no `o_short`.
  - Repeat with `i_rising` in cycle 17 → `o_short` in cycle 17, and the second press starts a new sequence.
- **Reset mid-gap:** assert `i_rst` in cycle 10 of the short-press stimulus → no pulse; `o_busy`=0 immediately; next `i_rising` is processed normally.
